// File: rtl/mandel_pkg.sv
// Shared types, constants and colour mapping for the Mandelbrot pixel engine.
// Fixed-point values are signed Q8.24.
package mandel_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int RBG_SIZE   = 24;
    localparam int FRAC_BITS  = 24;

    typedef logic signed [DATA_WIDTH-1:0] fixed_t;

    // One bit wider than fixed_t so |z|^2 near 4.0 cannot wrap
    localparam logic signed [DATA_WIDTH:0] ESCAPE_LIMIT =
        (DATA_WIDTH+1)'(4) << FRAC_BITS;

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        ITER,
        EMIT
    } state_t;

    function automatic logic [RBG_SIZE-1:0] iter_to_colour(
        input logic [7:0] iter,
        input logic [7:0] max_iter
    );
        return (iter == max_iter) ? '0
                                  : {iter, iter, 8'hFF - iter};
    endfunction

endpackage

// File: rtl/mandel_pixel_engine_if.sv
// Pixel write bus from the engine into the downstream queue.
// The engine drives the master side; the queue drives full_queue.
interface mandel_pixel_engine_if;
    import mandel_pkg::*;

    logic                  fin_flag;
    logic [RBG_SIZE-1:0]   colour_o;
    logic [DATA_WIDTH-1:0] xpixel_o;
    logic [DATA_WIDTH-1:0] ypixel_o;
    logic                  full_queue;

    modport master (
        output fin_flag, colour_o, xpixel_o, ypixel_o,
        input  full_queue
    );

    modport slave (
        input  fin_flag, colour_o, xpixel_o, ypixel_o,
        output full_queue
    );

endinterface

// File: rtl/mandel_iter_step.sv
// Combinational single step z <- z^2 + c with escape test on the current z.
// Products are full width, shifted by FRAC_BITS, then truncated.
module mandel_iter_step
    import mandel_pkg::*;
(
    input  fixed_t i_zr,
    input  fixed_t i_zi,
    input  fixed_t i_cr,
    input  fixed_t i_ci,
    output fixed_t o_zr_next,
    output fixed_t o_zi_next,
    output logic   o_escaped
);

    typedef logic signed [2*DATA_WIDTH-1:0] wide_t;

    wide_t                  w_zr_sq;
    wide_t                  w_zi_sq;
    wide_t                  w_zr_zi;
    fixed_t                 w_zr2;
    fixed_t                 w_zi2;
    fixed_t                 w_zrzi;
    logic signed [DATA_WIDTH:0] w_mag;

    assign w_zr_sq = wide_t'(i_zr) * wide_t'(i_zr);
    assign w_zi_sq = wide_t'(i_zi) * wide_t'(i_zi);
    assign w_zr_zi = wide_t'(i_zr) * wide_t'(i_zi);

    assign w_zr2  = fixed_t'(w_zr_sq >>> FRAC_BITS);
    assign w_zi2  = fixed_t'(w_zi_sq >>> FRAC_BITS);
    assign w_zrzi = fixed_t'(w_zr_zi >>> FRAC_BITS);

    assign w_mag = (DATA_WIDTH+1)'(w_zr2) + (DATA_WIDTH+1)'(w_zi2);

    assign o_escaped = w_mag >= ESCAPE_LIMIT;
    assign o_zr_next = w_zr2 - w_zi2 + i_cr;
    assign o_zi_next = (w_zrzi <<< 1) + i_ci;

endmodule

// File: rtl/mandel_pixel_engine.sv
// Raster-scan Mandelbrot engine: one iteration per cycle, one pixel
// pushed to the queue per EMIT, stalled by full_queue.
module mandel_pixel_engine
    import mandel_pkg::*;
#(
    parameter int     X_RES    = 640,
    parameter int     Y_RES    = 480,
    parameter int     MAX_ITER = 255,
    parameter fixed_t RE_START = -32'sh0200_0000,
    parameter fixed_t RE_STEP  = 32'sh0001_3333,
    parameter fixed_t IM_START = -32'sh0120_0000,
    parameter fixed_t IM_STEP  = 32'sh0001_3333
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    mandel_pixel_engine_if.master q_if,
    output logic                  busy,
    output logic                  frame_done
);

    state_t                r_state;
    state_t                w_next;
    logic [DATA_WIDTH-1:0] r_x;
    logic [DATA_WIDTH-1:0] r_y;
    fixed_t                r_cr;
    fixed_t                r_ci;
    fixed_t                r_zr;
    fixed_t                r_zi;
    fixed_t                w_zr_next;
    fixed_t                w_zi_next;
    logic [7:0]            r_iter;
    logic                  r_done;
    logic                  w_escaped;
    logic                  w_stop;
    logic                  w_accept;
    logic                  w_last_x;
    logic                  w_last_y;

    mandel_iter_step u_step (
        .i_zr      (r_zr),
        .i_zi      (r_zi),
        .i_cr      (r_cr),
        .i_ci      (r_ci),
        .o_zr_next (w_zr_next),
        .o_zi_next (w_zi_next),
        .o_escaped (w_escaped)
    );

    assign w_stop   = w_escaped || (r_iter == 8'(MAX_ITER));
    assign w_accept = (r_state == EMIT) && !q_if.full_queue;
    assign w_last_x = r_x == DATA_WIDTH'(X_RES - 1);
    assign w_last_y = r_y == DATA_WIDTH'(Y_RES - 1);

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next = INIT;
            INIT:    w_next = ITER;
            ITER:    if (w_stop) w_next = EMIT;
            EMIT:    if (w_accept)
                         w_next = (w_last_x && w_last_y) ? IDLE : INIT;
            default: w_next = IDLE;
        endcase
    end

    // c advances by accumulation; the last pixel rewinds the scan
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x    <= '0;
            r_y    <= '0;
            r_cr   <= RE_START;
            r_ci   <= IM_START;
            r_zr   <= '0;
            r_zi   <= '0;
            r_iter <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_accept && w_last_x && w_last_y;
            unique case (r_state)
                IDLE: if (start) begin
                    r_x  <= '0;
                    r_y  <= '0;
                    r_cr <= RE_START;
                    r_ci <= IM_START;
                end
                INIT: begin
                    r_zr   <= '0;
                    r_zi   <= '0;
                    r_iter <= '0;
                end
                ITER: if (!w_stop) begin
                    r_zr   <= w_zr_next;
                    r_zi   <= w_zi_next;
                    r_iter <= r_iter + 8'd1;
                end
                EMIT: if (w_accept) begin
                    if (!w_last_x) begin
                        r_x  <= r_x + DATA_WIDTH'(1);
                        r_cr <= r_cr + RE_STEP;
                    end else begin
                        r_x  <= '0;
                        r_cr <= RE_START;
                        if (!w_last_y) begin
                            r_y  <= r_y + DATA_WIDTH'(1);
                            r_ci <= r_ci + IM_STEP;
                        end else begin
                            r_y  <= '0;
                            r_ci <= IM_START;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy          = r_state != IDLE;
        q_if.fin_flag = w_accept;
        q_if.colour_o = '0;
        q_if.xpixel_o = '0;
        q_if.ypixel_o = '0;
        if (r_state == EMIT) begin
            q_if.colour_o = iter_to_colour(r_iter, 8'(MAX_ITER));
            q_if.xpixel_o = r_x;
            q_if.ypixel_o = r_y;
        end
    end

    assign frame_done = r_done;

endmodule

// File: tb/tb_mandel_pixel_engine.sv
// Scoreboard bench for mandel_pixel_engine on a 3x2 frame mixing
// non-escaping and fast-escaping pixels.
module tb_mandel_pixel_engine;
    import mandel_pkg::*;

    localparam int     XR   = 3;
    localparam int     YR   = 2;
    localparam int     MAXI = 255;
    localparam fixed_t RE0  = 32'sh0000_0000;
    localparam fixed_t RES  = 32'sh0200_0000;
    localparam fixed_t IM0  = 32'sh0000_0000;
    localparam fixed_t IMS  = 32'sh0040_0000;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [23:0] col;
        int          lat;
    } pix_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic busy;
    logic frame_done;

    mandel_pixel_engine_if q_if ();

    mandel_pixel_engine #(
        .X_RES    (XR),
        .Y_RES    (YR),
        .MAX_ITER (MAXI),
        .RE_START (RE0),
        .RE_STEP  (RES),
        .IM_START (IM0),
        .IM_STEP  (IMS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .q_if       (q_if),
        .busy       (busy),
        .frame_done (frame_done)
    );

    pix_t sb[$];
    pix_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   ref_cyc  = 0;
    int   n_done   = 0;
    int   n_strobe = 0;
    bit   lat_chk  = 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t",
                     tag, act, exp, $time);
        end
    endtask

    function automatic fixed_t fx_mul(input fixed_t a, input fixed_t b);
        logic signed [63:0] p;
        p = 64'(a) * 64'(b);
        return fixed_t'(p >>> FRAC_BITS);
    endfunction

    // Number of z updates before |z|^2 >= 4.0, capped at MAXI
    function automatic int escape_count(input fixed_t cr, input fixed_t ci);
        fixed_t zr, zi, a, b, p;
        logic signed [32:0] mag;
        zr = '0;
        zi = '0;
        for (int k = 0; k < MAXI; k++) begin
            a   = fx_mul(zr, zr);
            b   = fx_mul(zi, zi);
            mag = 33'(a) + 33'(b);
            if (mag >= 33'sh0_0400_0000) return k;
            p  = fx_mul(zr, zi);
            zr = a - b + cr;
            zi = p + p + ci;
        end
        return MAXI;
    endfunction

    function automatic logic [23:0] exp_colour(input int k);
        logic [7:0] i8;
        i8 = 8'(k);
        return (k == MAXI) ? 24'h0 : {i8, i8, 8'hFF - i8};
    endfunction

    // Call at posedge+1 with the engine idle
    task automatic start_frame();
        pix_t e;
        int   k;
        for (int y = 0; y < YR; y++) begin
            for (int x = 0; x < XR; x++) begin
                k = escape_count(fixed_t'(RE0 + 32'(x) * RES),
                                 fixed_t'(IM0 + 32'(y) * IMS));
                e.x   = 32'(x);
                e.y   = 32'(y);
                e.col = exp_colour(k);
                e.lat = k + 3;
                sb.push_back(e);
            end
        end
        ref_cyc = cyc;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int t;
        t = 0;
        do begin
            @(posedge clk);
            #1;
            t++;
        end while (!frame_done && t < budget);
        check("frame_done_seen", 32'(frame_done), 1);
        check("idle_after_done", 32'(busy), 0);
    endtask

    always @(negedge clk) begin
        if (!reset && q_if.fin_flag) begin
            n_strobe++;
            if (sb.size() == 0) begin
                check("stray_strobe", 32'(q_if.fin_flag), 0);
            end else begin
                mon_e = sb.pop_front();
                check("pix_x", q_if.xpixel_o, mon_e.x);
                check("pix_y", q_if.ypixel_o, mon_e.y);
                check("pix_colour", 32'(q_if.colour_o), 32'(mon_e.col));
                if (lat_chk)
                    check("pix_latency", 32'(cyc - ref_cyc), 32'(mon_e.lat));
            end
            ref_cyc = cyc;
        end
        if (!reset && frame_done) n_done++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        q_if.full_queue = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_busy", 32'(busy), 0);
        check("rst_fin", 32'(q_if.fin_flag), 0);
        check("rst_colour", 32'(q_if.colour_o), 0);
        check("rst_x", q_if.xpixel_o, 0);
        check("rst_y", q_if.ypixel_o, 0);
        check("rst_done", 32'(frame_done), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Frame 1 with a start pulse while busy
        start_frame();
        repeat (100) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(4000);

        // Frame 2 started in the frame_done cycle
        start_frame();
        wait_done(4000);
        @(negedge clk);
        #1;
        check("f2_done_cnt", 32'(n_done), 2);
        check("f2_strobes", 32'(n_strobe), 12);
        check("f2_sb_empty", 32'(sb.size()), 0);

        // Frame 3 under backpressure
        @(posedge clk);
        #1;
        lat_chk         = 1'b0;
        q_if.full_queue = 1'b1;
        start_frame();
        repeat (257) @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            #2;
            check("bp0_fin", 32'(q_if.fin_flag), 0);
            check("bp0_x", q_if.xpixel_o, 0);
            check("bp0_busy", 32'(busy), 1);
            @(posedge clk);
        end
        #1 q_if.full_queue = 1'b0;
        #1 check("bp0_release_fin", 32'(q_if.fin_flag), 1);
        @(posedge clk);
        #1 q_if.full_queue = 1'b1;
        repeat (3) @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            #2;
            check("bp1_fin", 32'(q_if.fin_flag), 0);
            check("bp1_x", q_if.xpixel_o, 1);
            check("bp1_y", q_if.ypixel_o, 0);
            check("bp1_colour", 32'(q_if.colour_o), 32'h0101FE);
            @(posedge clk);
        end
        #1 q_if.full_queue = 1'b0;
        #1 check("bp1_release_fin", 32'(q_if.fin_flag), 1);
        wait_done(4000);
        lat_chk = 1'b1;
        @(negedge clk);
        #1;
        check("f3_done_cnt", 32'(n_done), 3);
        check("f3_strobes", 32'(n_strobe), 18);

        // Frame 4 aborted by reset during ITER of pixel (1,0)
        @(posedge clk);
        #1;
        start_frame();
        repeat (259) @(posedge clk);
        #1 reset = 1'b1;
        sb.delete();
        @(posedge clk);
        #2;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_fin", 32'(q_if.fin_flag), 0);
        check("mid_rst_colour", 32'(q_if.colour_o), 0);
        check("mid_rst_x", q_if.xpixel_o, 0);
        check("mid_rst_y", q_if.ypixel_o, 0);
        check("mid_rst_done", 32'(frame_done), 0);
        reset = 1'b0;

        // Frame 5 restarts cleanly from (0,0)
        @(posedge clk);
        #1;
        start_frame();
        wait_done(4000);
        @(negedge clk);
        #1;
        check("final_done_cnt", 32'(n_done), 4);
        check("final_strobes", 32'(n_strobe), 25);
        check("final_sb_empty", 32'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
